// File: rtl/pd_timer_pkg.sv
// Shared types and default lengths for the packet-decoder byte timer.
package pd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } pd_timer_state_t;

  localparam int PD_HDR_LEN = 64;
  localparam int PD_MAX_LEN = 80;

endpackage

// File: rtl/pd_byte_cnt.sv
// Byte up-counter with synchronous reset, clear and enable.
module pd_byte_cnt #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pd_packet_timer.sv
// Packet byte timer: latches length on start, pulses at header and end.
module pd_packet_timer
  import pd_timer_pkg::*;
#(
  parameter int CNT_W   = 7,
  parameter int HDR_LEN = PD_HDR_LEN,
  parameter int MAX_LEN = PD_MAX_LEN
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pkt_len,
  input  logic             cnt_up,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] byte_count,
  output logic             hdr_done,
  output logic             packet_done,
  output logic             busy,
  output logic             len_err
);

  if (!(HDR_LEN < MAX_LEN && MAX_LEN < (1 << CNT_W))) begin : g_bad_cfg
    $error("pd_packet_timer: need HDR_LEN < MAX_LEN < 2**CNT_W");
  end

  pd_timer_state_t  state, state_n;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             len_ok;
  logic             cnt_clr, cnt_en;
  logic             hdr_d, pkt_d;

  pd_byte_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (byte_count)
  );

  assign cnt_inc = byte_count + CNT_W'(1);
  assign len_ok  = (pkt_len != '0) &&
                   (pkt_len <= CNT_W'(MAX_LEN));

  always_comb begin
    state_n = state;
    len_d   = len_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    hdr_d   = 1'b0;
    pkt_d   = 1'b0;
    if (clr_cnt) begin
      state_n = IDLE;
      len_d   = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state)
        COUNT: begin
          if (cnt_up) begin
            cnt_en = 1'b1;
            hdr_d  = (cnt_inc == CNT_W'(HDR_LEN)) &&
                     (len_q > CNT_W'(HDR_LEN));
            if (cnt_inc == len_q) begin
              state_n = DONE;
              pkt_d   = 1'b1;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERR all accept a new packet start
          if (state == DONE) state_n = IDLE;
          if (start) begin
            if (len_ok) begin
              state_n = COUNT;
              len_d   = pkt_len;
              cnt_clr = 1'b1;
            end else begin
              state_n = ERR;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      len_q       <= '0;
      hdr_done    <= 1'b0;
      packet_done <= 1'b0;
      busy        <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      state       <= state_n;
      len_q       <= len_d;
      hdr_done    <= hdr_d;
      packet_done <= pkt_d;
      busy        <= (state_n == COUNT);
      len_err     <= (state_n == ERR);
    end
  end

endmodule

// File: tb/tb_pd_packet_timer.sv
// Directed self-checking bench for pd_packet_timer.
module tb_pd_packet_timer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic [6:0] pkt_len;
  logic       cnt_up;
  logic       clr_cnt;
  logic [6:0] byte_count;
  logic       hdr_done;
  logic       packet_done;
  logic       busy;
  logic       len_err;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pd_packet_timer dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .pkt_len     (pkt_len),
    .cnt_up      (cnt_up),
    .clr_cnt     (clr_cnt),
    .byte_count  (byte_count),
    .hdr_done    (hdr_done),
    .packet_done (packet_done),
    .busy        (busy),
    .len_err     (len_err)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic s, input int l,
                     input logic u, input logic c);
    start   = s;
    pkt_len = 7'(l);
    cnt_up  = u;
    clr_cnt = c;
    @(posedge clk);
    #1;
    start   = 1'b0;
    pkt_len = '0;
    cnt_up  = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int cnt,
                         input int h, input int p,
                         input int b, input int e);
    chk({tag, ".cnt"}, int'(byte_count), cnt);
    chk({tag, ".hdr"}, int'(hdr_done), h);
    chk({tag, ".pkt"}, int'(packet_done), p);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".err"}, int'(len_err), e);
  endtask

  // One COUNT-state cycle against a packet of length len.
  task automatic step_byte(input string tag, input logic up,
                           input int len);
    cyc(1'b0, 0, up, 1'b0);
    if (up) exp_cnt++;
    chk_all(tag, exp_cnt,
            int'(up && exp_cnt == 64 && len > 64),
            int'(up && exp_cnt == len),
            int'(exp_cnt < len), 0);
  endtask

  task automatic begin_pkt(input string tag, input int len);
    cyc(1'b1, len, 1'b0, 1'b0);
    exp_cnt = 0;
    chk_all(tag, 0, 0, 0, 1, 0);
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    pkt_len = '0;
    cnt_up = 1'b0;
    clr_cnt = 1'b0;
    cyc(1'b1, 10, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk_all("reset", 0, 0, 0, 0, 0);
    n_rst = 1'b1;

    // Full-length packet, back to back bytes
    begin_pkt("p80.start", 80);
    for (int i = 0; i < 80; i++) step_byte("p80", 1'b1, 80);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk_all("p80.idle", 80, 0, 0, 0, 0);

    // Length equal to header: no header pulse, back-to-back start
    begin_pkt("p64.start", 64);
    for (int i = 0; i < 64; i++) step_byte("p64", 1'b1, 64);
    begin_pkt("b2b.start", 10);
    for (int i = 0; i < 10; i++) step_byte("b2b", 1'b1, 10);

    // Illegal lengths
    cyc(1'b1, 0, 1'b0, 1'b0);
    chk_all("len0", 10, 0, 0, 0, 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk_all("err.up", 10, 0, 0, 0, 1);
    cyc(1'b1, 81, 1'b0, 1'b0);
    chk_all("len81", 10, 0, 0, 0, 1);
    begin_pkt("err.recover", 10);
    for (int i = 0; i < 10; i++) step_byte("rec", 1'b1, 10);

    // Gapped bytes
    begin_pkt("gap.start", 80);
    while (exp_cnt < 80) begin
      repeat ($urandom_range(0, 2)) step_byte("gap.idle", 1'b0, 80);
      step_byte("gap.up", 1'b1, 80);
    end

    // clr_cnt with cnt_up at count 40
    begin_pkt("clr.start", 80);
    for (int i = 0; i < 40; i++) step_byte("clr.pre", 1'b1, 80);
    cyc(1'b0, 0, 1'b1, 1'b1);
    chk_all("clr", 0, 0, 0, 0, 0);
    for (int i = 0; i < 45; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk_all("clr.post", 0, 0, 0, 0, 0);
    end

    // Reset at count 70
    begin_pkt("rst.start", 80);
    for (int i = 0; i < 70; i++) step_byte("rst.pre", 1'b1, 80);
    n_rst = 1'b0;
    cyc(1'b0, 0, 1'b1, 1'b0);
    n_rst = 1'b1;
    chk_all("rst", 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk_all("rst.post", 0, 0, 0, 0, 0);
    end

    // start in COUNT is ignored
    begin_pkt("mid.start", 30);
    for (int i = 0; i < 20; i++) step_byte("mid.pre", 1'b1, 30);
    cyc(1'b1, 5, 1'b1, 1'b0);
    exp_cnt++;
    chk_all("mid.ign", 21, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step_byte("mid.post", 1'b1, 30);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk_all("mid.idle", 30, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pd_packet_timer.md
# pd_packet_timer

Parametrised byte timer for the packet decoder. It counts accepted bytes against a packet length latched at packet start. It emits a one-cycle header-boundary pulse and a one-cycle end-of-packet pulse, and flags illegal lengths. It sits between the packet-decoder FSM, which drives `start`, `cnt_up` and `clr_cnt`, and the downstream block/header assembly logic.

## Interface
Parameters:
- `CNT_W`, 7: width of the byte counter and of `pkt_len`; must satisfy `2**CNT_W > MAX_LEN`.
- `HDR_LEN`, 64: byte count at which the header-boundary pulse fires.
- `MAX_LEN`, 80: largest legal packet length in bytes.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `n_rst`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin a new packet; samples `pkt_len` on this edge.
- `pkt_len`, in, CNT_W: packet length in bytes; legal range 1..MAX_LEN.
- `cnt_up`, in, 1: one byte accepted this cycle.
- `clr_cnt`, in, 1: abort the packet and clear the timer.
- `byte_count`, out, CNT_W: bytes counted in the current or last packet.
- `hdr_done`, out, 1: one-cycle pulse, header boundary reached.
- `packet_done`, out, 1: one-cycle pulse, last byte of packet reached.
- `busy`, out, 1: high in COUNT.
- `len_err`, out, 1: high in ERR.

## Operation
States and transitions:
- IDLE
  - `start` with legal `pkt_len`: latch `len_q`, set `byte_count` to 0, go to COUNT.
  - `start` with `pkt_len` equal to 0 or greater than MAX_LEN: go to ERR.
- COUNT
  - `cnt_up`: `byte_count` increments by 1.
  - Increment that makes the count equal `len_q`: go to DONE.
  - `start`: ignored.
- DONE (exactly one cycle)
  - `packet_done` is 1.
  - Next state is IDLE, or COUNT/ERR if `start` is present; a `start` in DONE is evaluated as in IDLE, allowing back-to-back packets.
- ERR
  - `len_err` is 1.
  - Leaves on `start` with legal length (to COUNT) or on `clr_cnt` (to IDLE).

Priority:
- `n_rst` low overrides everything.
- `clr_cnt` is next: state goes to IDLE, `byte_count` to 0, `len_q` to 0; a simultaneous `start` or `cnt_up` is dropped.
- `cnt_up` in IDLE, DONE and ERR is ignored.
- `byte_count` holds its final value in DONE and IDLE until the next `start` or `clr_cnt`.

Header pulse:
- `hdr_done` fires only when `len_q > HDR_LEN` and the count reaches HDR_LEN.
- If `len_q <= HDR_LEN`, only `packet_done` fires.

Arithmetic:
- Unsigned CNT_W-bit values. In COUNT the counter never exceeds `len_q`, so it cannot wrap.
- Length comparisons against MAX_LEN and HDR_LEN are made at CNT_W bits.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - `byte_count` 0
  - `hdr_done` 0
  - `packet_done` 0
  - `busy` 0
  - `len_err` 0
- `start` on edge N: `busy` is 1 from edge N.
- Pulse latency: the `cnt_up` on edge K that brings the count to HDR_LEN or to `len_q` produces `byte_count` = that value and `hdr_done` or `packet_done` = 1 from edge K, for exactly one cycle.
- `busy` drops on the same edge that `packet_done` rises.
- Minimum packet period is `len_q` + 1 cycles, since DONE costs one cycle.
- Reset or `clr_cnt` mid-packet suppresses any pending pulse; no `packet_done` is produced for an aborted packet.

## Structure
- Package `pd_timer_pkg`:
  - `pd_timer_state_t` enum (IDLE, COUNT, DONE, ERR).
  - Default constants `PD_HDR_LEN` = 64 and `PD_MAX_LEN` = 80.
- One sub-module, `pd_byte_cnt`: CNT_W-bit up-counter with synchronous active-low reset, synchronous clear and enable.
- The FSM, length latch and comparators live in the top module.
- Elaboration-time check: `HDR_LEN < MAX_LEN < 2**CNT_W`.

## Test plan
- Defaults, `start` with `pkt_len` = 80, then 80 consecutive `cnt_up`:
  - `hdr_done` pulses once, with `byte_count` = 64.
  - `packet_done` pulses once, with `byte_count` = 80.
  - `busy` is high for 80 cycles.
- `pkt_len` = 64:
  - no `hdr_done`.
  - `packet_done` after the 64th `cnt_up`.
  - `start` asserted in the DONE cycle begins the next packet with `byte_count` = 0.
- `pkt_len` = 0, then `pkt_len` = 81:
  - ERR entered, `len_err` = 1, `busy` = 0.
  - `cnt_up` ignored.
  - A subsequent `start` with `pkt_len` = 10 clears `len_err`, and `packet_done` follows after 10 bytes.
- Gapped `cnt_up` (random idle cycles) with `pkt_len` = 80:
  - `byte_count` advances only on `cnt_up`.
  - Pulses occur on the same edges as the corresponding `cnt_up`.
- `clr_cnt` and `cnt_up` together at count 40, also `n_rst` low at count 70:
  - state IDLE, `byte_count` = 0.
  - no `hdr_done` or `packet_done` ever issued for that packet.
- `start` asserted mid-COUNT at count 20: ignored; packet completes at the original `len_q`.
